csr_serialize_ctrl: RTL and testbench
=====================================

// Module: csr_serialize_ctrl
// PURPOSE
//  Serializes CSR instructions. When a CSR op sits in DE, it stalls the front end and injects EX
//  bubbles until EX/M1/M2/WB are empty. It then runs a req/ack transaction with the CSR file and
//  releases the CSR op into EX. Finally it flushes F1/F2 and redirects fetch to csr_pc+4.
//  Stall/flush outputs are ORed at top level with the load-use hazard eliminator's outputs.
// PARAMETERS
//  XLEN         32  PC / CSR data width
//  TIMEOUT_CYC  64  max cycles in DRAIN+ISSUE before watchdog abort (only with CSR_WDOG_EN)
// PORTS
//  clk             in   1     clock; single clock domain
//  rst             in   1     synchronous, active-high reset
//  de_valid        in   1     DE holds a valid instruction
//  de_is_csr_op    in   1     DE instruction is a CSR op
//  de_pc           in   XLEN  PC of DE instruction
//  ex_is_a_inst    in   1     EX occupied (same for m1/m2/wb below)
//  m1_is_a_inst    in   1
//  m2_is_a_inst    in   1
//  wb_is_a_inst    in   1
//  ext_flush       in   1     older-instruction redirect (branch/trap) from a later stage
//  csr_req         out  1     CSR file access request; held until csr_ack
//  csr_ack         in   1     CSR file done; may be high in the first csr_req cycle
//  stall_pc        out  1     hold PC
//  stall_f2        out  1     hold F2
//  stall_de        out  1     hold DE
//  flush_ex        out  1     inject bubble into EX
//  flush_f2        out  1     kill F1/F2 contents; bubble into DE
//  redirect_valid  out  1     1-cycle pulse: fetch from redirect_pc
//  redirect_pc     out  XLEN  csr_pc_q + 4, modulo 2^XLEN
//  busy            out  1     state != IDLE
//  timeout_err     out  1     sticky watchdog flag
// BEHAVIOUR
//  Reset: state=IDLE, csr_pc_q=0, all outputs 0, redirect_pc=4, wdog counter=0.
//  detect = de_valid & de_is_csr_op & ~ext_flush; empty = ~(ex|m1|m2|wb _is_a_inst).
//  States (enum csr_ser_state_e):
//   IDLE: on detect, latch csr_pc_q<=de_pc; go ISSUE if empty, else DRAIN.
//         Stalls are combinational in the detect cycle:
//         stall_pc/f2/de=1, flush_ex=1, so the CSR op stays in DE with zero-cycle latency.
//   DRAIN: stall_pc/f2/de=1, flush_ex=1. ext_flush -> IDLE, all outputs 0 that cycle
//          (CSR op is wrong-path). Else empty -> ISSUE.
//   ISSUE: csr_req=1, stall_pc/f2/de=1, flush_ex=1. csr_ack -> RELEASE.
//          ext_flush is illegal here because the pipe is empty (SVA); it is ignored.
//   RELEASE (1 cycle): stalls=0, flush_ex=0, so the CSR op advances to EX.
//          flush_f2=1, redirect_valid=1, redirect_pc=csr_pc_q+4. Next state is IDLE.
//          A CSR op in DE during this cycle is killed by flush_f2 and is not detected.
//  Latency, empty pipe, ack in 1st req cycle: detect@T, csr_req@T+1, RELEASE@T+2, IDLE@T+3.
//  Back-to-back CSR ops: the 2nd op is refetched after the redirect and serialized again.
//  rst mid-operation: immediate return to IDLE; csr_req drops in the same cycle the reset is sampled.
// CONFIGURATION
//  `CSR_WDOG_EN defined:
//   - Counter clears on IDLE and increments in DRAIN/ISSUE.
//   - When count==TIMEOUT_CYC-1 and no exit occurs in that cycle, the FSM goes to IDLE with no redirect.
//   - csr_req drops and timeout_err sets; timeout_err stays set until rst.
//  Not defined: no counter; timeout_err tied 0; DRAIN/ISSUE wait indefinitely.
// STRUCTURE
//  risc_pipe_pkg holds csr_ser_state_e (IDLE, DRAIN, ISSUE, RELEASE) and the XLEN default,
//  next to the existing MEM_* op encodings.
//  Sub-module csr_drain_watchdog (counter + sticky flag) is instantiated only under CSR_WDOG_EN.
//  Everything else is one FSM in this module.
// TESTING
//  1 Empty pipe; de_pc=0x100 CSR, ack 1st cycle -> csr_req@T+1; redirect 0x104 + flush_f2 @T+2.
//  2 ex=m1=1 at detect, both clear after 2 cycles -> DRAIN 2 cycles, flush_ex=1 throughout,
//    csr_req only after empty.
//  3 ext_flush in DRAIN -> IDLE next cycle; no csr_req, no redirect; busy=0.
//  4 csr_ack delayed 5 cycles -> csr_req held 5 cycles; stalls held; single redirect pulse.
//  5 rst during ISSUE -> csr_req=0 and all outputs at reset values next cycle.
//  6 CSR_WDOG_EN, TIMEOUT_CYC=8, ack never -> abort after 8 DRAIN+ISSUE cycles;
//    timeout_err=1 and stays set; no redirect; de_pc=0xFFFFFFFC wraps redirect_pc to 0.

Source files
------------

// File: rtl/risc_pipe_pkg.sv
// Shared pipeline types: memory-op encodings and the CSR serializer state type.
package risc_pipe_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    ISSUE   = 2'd2,
    RELEASE = 2'd3
  } csr_ser_state_e;

endpackage

// File: rtl/csr_drain_watchdog.sv
// Cycle counter for the DRAIN/ISSUE phases with a sticky timeout flag.
module csr_drain_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic exit_i,
  output logic abort_o,
  output logic err_o
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  // Abort only when the last allowed cycle would not already leave the wait phase.
  assign abort_o = active_i && (count_q == CW'(TIMEOUT_CYC - 1)) && !exit_i;
  assign err_o   = err_q;

  always_comb begin
    count_d = '0;
    err_d   = err_q | abort_o;
    if (active_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/csr_serialize_ctrl.sv
// CSR serializer: drains EX..WB, runs the CSR req/ack, releases the op and redirects to pc+4.
// Optional watchdog abort of DRAIN/ISSUE is enabled by defining CSR_WDOG_EN.
module csr_serialize_ctrl
  import risc_pipe_pkg::*;
#(
  parameter int unsigned XLEN        = XLEN_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            de_valid,
  input  logic            de_is_csr_op,
  input  logic [XLEN-1:0] de_pc,
  input  logic            ex_is_a_inst,
  input  logic            m1_is_a_inst,
  input  logic            m2_is_a_inst,
  input  logic            wb_is_a_inst,
  input  logic            ext_flush,
  output logic            csr_req,
  input  logic            csr_ack,
  output logic            stall_pc,
  output logic            stall_f2,
  output logic            stall_de,
  output logic            flush_ex,
  output logic            flush_f2,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy,
  output logic            timeout_err
);

  csr_ser_state_e  state_q, state_d;
  logic [XLEN-1:0] csr_pc_q, csr_pc_d;
  logic            detect, empty, hold;
  logic            wdog_abort;

  assign detect = de_valid && de_is_csr_op && !ext_flush;
  assign empty  = !(ex_is_a_inst || m1_is_a_inst || m2_is_a_inst || wb_is_a_inst);

`ifdef CSR_WDOG_EN
  logic wdog_active, wdog_exit;
  assign wdog_active = (state_q == DRAIN) || (state_q == ISSUE);
  assign wdog_exit   = ((state_q == DRAIN) && ext_flush) || ((state_q == ISSUE) && csr_ack);

  csr_drain_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .active_i(wdog_active),
    .exit_i  (wdog_exit),
    .abort_o (wdog_abort),
    .err_o   (timeout_err)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign wdog_abort         = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    csr_pc_d       = csr_pc_q;
    hold           = 1'b0;
    csr_req        = 1'b0;
    flush_f2       = 1'b0;
    redirect_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (detect) begin
          hold     = 1'b1;
          csr_pc_d = de_pc;
          state_d  = empty ? ISSUE : DRAIN;
        end
      end
      DRAIN: begin
        if (ext_flush) begin
          state_d = IDLE;
        end else begin
          hold = 1'b1;
          if (wdog_abort)  state_d = IDLE;
          else if (empty)  state_d = ISSUE;
        end
      end
      ISSUE: begin
        hold    = 1'b1;
        csr_req = 1'b1;
        if (csr_ack)         state_d = RELEASE;
        else if (wdog_abort) state_d = IDLE;
      end
      RELEASE: begin
        flush_f2       = 1'b1;
        redirect_valid = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall_pc    = hold;
  assign stall_f2    = hold;
  assign stall_de    = hold;
  assign flush_ex    = hold;
  assign busy        = (state_q != IDLE);
  assign redirect_pc = csr_pc_q + XLEN'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      csr_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      csr_pc_q <= csr_pc_d;
    end
  end

  // Older-instruction redirects cannot arrive once the pipe behind DE is empty.
  a_no_flush_in_issue: assert property (@(posedge clk) disable iff (rst)
    !((state_q == ISSUE) && ext_flush));

endmodule

// File: tb/tb_csr_serialize_ctrl.sv
// Directed bench for csr_serialize_ctrl with a redirect-target scoreboard.
module tb_csr_serialize_ctrl;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            de_valid, de_is_csr_op;
  logic [XLEN-1:0] de_pc;
  logic            ex_is_a_inst, m1_is_a_inst, m2_is_a_inst, wb_is_a_inst;
  logic            ext_flush, csr_ack;
  logic            csr_req, stall_pc, stall_f2, stall_de, flush_ex, flush_f2;
  logic            redirect_valid, busy, timeout_err;
  logic [XLEN-1:0] redirect_pc;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [XLEN-1:0] exp_q[$];

  csr_serialize_ctrl #(
    .XLEN       (XLEN),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .de_valid      (de_valid),
    .de_is_csr_op  (de_is_csr_op),
    .de_pc         (de_pc),
    .ex_is_a_inst  (ex_is_a_inst),
    .m1_is_a_inst  (m1_is_a_inst),
    .m2_is_a_inst  (m2_is_a_inst),
    .wb_is_a_inst  (wb_is_a_inst),
    .ext_flush     (ext_flush),
    .csr_req       (csr_req),
    .csr_ack       (csr_ack),
    .stall_pc      (stall_pc),
    .stall_f2      (stall_f2),
    .stall_de      (stall_de),
    .flush_ex      (flush_ex),
    .flush_f2      (flush_f2),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit exceeded");
  end

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven for the new cycle.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Settle combinational outputs and retire any redirect against the scoreboard.
  task automatic settle();
    logic [XLEN-1:0] exp_pc;
    #1;
    if (redirect_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_redirect", 32'd1, 32'd0);
      end else begin
        exp_pc = exp_q.pop_front();
        check("sb_redirect_pc", redirect_pc, exp_pc);
      end
    end
  endtask

  task automatic set_pipe(input logic ex, input logic m1, input logic m2, input logic wb);
    ex_is_a_inst = ex;
    m1_is_a_inst = m1;
    m2_is_a_inst = m2;
    wb_is_a_inst = wb;
  endtask

  task automatic check_hold(input string tag, input logic exp);
    check({tag, "_stall_pc"}, {31'd0, stall_pc}, {31'd0, exp});
    check({tag, "_stall_f2"}, {31'd0, stall_f2}, {31'd0, exp});
    check({tag, "_stall_de"}, {31'd0, stall_de}, {31'd0, exp});
    check({tag, "_flush_ex"}, {31'd0, flush_ex}, {31'd0, exp});
  endtask

  initial begin
    rst = 1'b1; de_valid = 1'b0; de_is_csr_op = 1'b0; de_pc = '0;
    set_pipe(1'b0, 1'b0, 1'b0, 1'b0);
    ext_flush = 1'b0; csr_ack = 1'b0;
    next_cycle(); next_cycle();
    rst = 1'b0;
    settle();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_csr_req", {31'd0, csr_req}, 32'd0);
    check("rst_flush_f2", {31'd0, flush_f2}, 32'd0);
    check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'h4);
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    check_hold("rst", 1'b0);

    // 1: empty pipe, ack in first req cycle
    next_cycle();
    de_valid = 1'b1; de_is_csr_op = 1'b1; de_pc = 32'h100;
    exp_q.push_back(32'h104);
    settle();
    check_hold("t1_detect", 1'b1);
    check("t1_detect_req", {31'd0, csr_req}, 32'd0);
    next_cycle();
    csr_ack = 1'b1;
    settle();
    check("t1_req", {31'd0, csr_req}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check_hold("t1_issue", 1'b1);
    next_cycle();
    csr_ack = 1'b0;
    settle();
    check("t1_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    check("t1_flush_f2", {31'd0, flush_f2}, 32'd1);
    check("t1_rel_req", {31'd0, csr_req}, 32'd0);
    check_hold("t1_release", 1'b0);
    next_cycle();
    de_valid = 1'b0; de_is_csr_op = 1'b0;
    settle();
    check("t1_idle_busy", {31'd0, busy}, 32'd0);
    check("t1_idle_redirect", {31'd0, redirect_valid}, 32'd0);

    // 2: ex/m1 occupied for the detect cycle and one DRAIN cycle
    next_cycle();
    de_valid = 1'b1; de_is_csr_op = 1'b1; de_pc = 32'h200;
    set_pipe(1'b1, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(32'h204);
    settle();
    check_hold("t2_detect", 1'b1);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      if (i == 1) set_pipe(1'b0, 1'b0, 1'b0, 1'b0);
      settle();
      check("t2_drain_busy", {31'd0, busy}, 32'd1);
      check("t2_drain_req", {31'd0, csr_req}, 32'd0);
      check_hold("t2_drain", 1'b1);
    end
    next_cycle();
    csr_ack = 1'b1;
    settle();
    check("t2_issue_req", {31'd0, csr_req}, 32'd1);
    next_cycle();
    csr_ack = 1'b0;
    settle();
    check("t2_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    next_cycle();
    de_valid = 1'b0; de_is_csr_op = 1'b0;
    settle();
    check("t2_idle_busy", {31'd0, busy}, 32'd0);

    // 3: ext_flush while draining abandons the op
    next_cycle();
    de_valid = 1'b1; de_is_csr_op = 1'b1; de_pc = 32'h300;
    set_pipe(1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    next_cycle();
    ext_flush = 1'b1;
    settle();
    check("t3_flush_busy", {31'd0, busy}, 32'd1);
    check("t3_flush_req", {31'd0, csr_req}, 32'd0);
    check_hold("t3_flush", 1'b0);
    next_cycle();
    ext_flush = 1'b0; de_valid = 1'b0; de_is_csr_op = 1'b0;
    set_pipe(1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    check("t3_idle_busy", {31'd0, busy}, 32'd0);
    check("t3_idle_req", {31'd0, csr_req}, 32'd0);
    check("t3_idle_redirect", {31'd0, redirect_valid}, 32'd0);

    // 4: ack arrives in the fifth req cycle
    next_cycle();
    de_valid = 1'b1; de_is_csr_op = 1'b1; de_pc = 32'h400;
    exp_q.push_back(32'h404);
    settle();
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      csr_ack = (i == 4);
      settle();
      check("t4_req_held", {31'd0, csr_req}, 32'd1);
      check("t4_no_redirect", {31'd0, redirect_valid}, 32'd0);
      check_hold("t4_issue", 1'b1);
    end
    next_cycle();
    csr_ack = 1'b0;
    settle();
    check("t4_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    next_cycle();
    de_valid = 1'b0; de_is_csr_op = 1'b0;
    settle();
    check("t4_single_pulse", {31'd0, redirect_valid}, 32'd0);

    // 5: reset while in ISSUE
    next_cycle();
    de_valid = 1'b1; de_is_csr_op = 1'b1; de_pc = 32'h500;
    settle();
    next_cycle();
    settle();
    check("t5_issue_req", {31'd0, csr_req}, 32'd1);
    rst = 1'b1; de_valid = 1'b0; de_is_csr_op = 1'b0;
    next_cycle();
    settle();
    check("t5_rst_req", {31'd0, csr_req}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_redirect_pc", redirect_pc, 32'h4);
    check_hold("t5_rst", 1'b0);
    rst = 1'b0;

    // 6: ack never arrives; de_pc at the top of the address space
    next_cycle();
    de_valid = 1'b1; de_is_csr_op = 1'b1; de_pc = 32'hFFFF_FFFC;
    set_pipe(1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      if (i == 2) set_pipe(1'b0, 1'b0, 1'b0, 1'b0);
      settle();
      check("t6_wait_busy", {31'd0, busy}, 32'd1);
      check("t6_wrap_pc", redirect_pc, 32'h0);
    end
`ifdef CSR_WDOG_EN
    next_cycle();
    de_valid = 1'b0; de_is_csr_op = 1'b0;
    settle();
    check("t6_abort_busy", {31'd0, busy}, 32'd0);
    check("t6_abort_req", {31'd0, csr_req}, 32'd0);
    check("t6_abort_redirect", {31'd0, redirect_valid}, 32'd0);
    check("t6_timeout_err", {31'd0, timeout_err}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      settle();
      check("t6_err_sticky", {31'd0, timeout_err}, 32'd1);
    end
`else
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      settle();
      check("t6_waits_busy", {31'd0, busy}, 32'd1);
      check("t6_waits_req", {31'd0, csr_req}, 32'd1);
      check("t6_no_err", {31'd0, timeout_err}, 32'd0);
    end
    de_valid = 1'b0; de_is_csr_op = 1'b0;
`endif
    rst = 1'b1;
    next_cycle();
    settle();
    check("t6_rst_err", {31'd0, timeout_err}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    next_cycle();
    settle();

    check("sb_all_retired", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
